// File: rtl/ooo_bypass_pkg.sv
// rtl/ooo_bypass_pkg.sv - shared types and sizing helpers for the operand bypass network
// Purpose: default widths, the result-entry layout and the level-index width helper
//          used by ooo_bypass_network and ooo_bypass_lookup.
// Ports:   none (package).
package ooo_bypass_pkg;

  localparam int DEF_NUM_FU     = 4;
  localparam int DEF_NUM_SRC    = 2;
  localparam int DEF_HIST_DEPTH = 2;
  localparam int DEF_REG_W      = 5;
  localparam int DEF_DATA_W     = 32;

  // One forwarding entry at the default widths: {valid, rd, data}.
  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_W-1:0]  rd;
    logic [DEF_DATA_W-1:0] data;
  } bypass_entry_t;

  // Width of a hit-level index: levels 0 (live) .. hist_depth.
  function automatic int lvl_width(input int hist_depth);
    return (hist_depth < 1) ? 1 : $clog2(hist_depth + 1);
  endfunction

endpackage

// File: rtl/ooo_bypass_lookup.sv
// rtl/ooo_bypass_lookup.sv - single-port priority search over a flattened entry array
// Purpose: finds the lowest-index valid entry whose rd matches src_reg; entries are
//          ordered newest level first, lowest channel first, so index order is priority.
// Ports:   enable     - global lookup enable (low during reset or flush)
//          ent_valid  - per-entry valid, ent_rd / ent_data - flattened entry fields
//          src_reg    - register being looked up (x0 never hits)
//          hit / hit_data / hit_level - result; data and level are 0 on a miss
module ooo_bypass_lookup
  import ooo_bypass_pkg::*;
#(
  parameter int NUM_ENT     = 12,
  parameter int ENT_PER_LVL = 4,
  parameter int REG_W       = 5,
  parameter int DATA_W      = 32,
  parameter int LVL_W       = 2
) (
  input  logic                      enable,
  input  logic [NUM_ENT-1:0]        ent_valid,
  input  logic [NUM_ENT*REG_W-1:0]  ent_rd,
  input  logic [NUM_ENT*DATA_W-1:0] ent_data,
  input  logic [REG_W-1:0]          src_reg,
  output logic                      hit,
  output logic [DATA_W-1:0]         hit_data,
  output logic [LVL_W-1:0]          hit_level
);

  // Scan from the oldest entry downward so that the last match written is the
  // lowest index, i.e. newest level and lowest channel.
  always_comb begin
    hit       = 1'b0;
    hit_data  = '0;
    hit_level = '0;
    if (enable && (src_reg != '0)) begin
      for (int i = NUM_ENT - 1; i >= 0; i--) begin
        if (ent_valid[i] && (ent_rd[i*REG_W +: REG_W] == src_reg)) begin
          hit       = 1'b1;
          hit_data  = ent_data[i*DATA_W +: DATA_W];
          hit_level = LVL_W'(i / ENT_PER_LVL);
        end
      end
    end
  end

endmodule

// File: rtl/ooo_bypass_network.sv
// rtl/ooo_bypass_network.sv - operand forwarding network with registered result history
// Purpose: forwards FU results (live and HIST_DEPTH registered levels) to NUM_SRC
//          source lookups, and counts cycles with any hit.
// Ports:   CLK, nRST (sync active-low) - clock / reset
//          flush - clears history next edge, masks all lookups this cycle
//          hold  - freezes history contents
//          fu_valid / fu_rd / fu_data - per-channel writeback results
//          src_reg - per-port lookup register
//          src_bypass_ena / _data / _level - per-port lookup result
//          hit_count - saturating count of cycles with any hit
module ooo_bypass_network
  import ooo_bypass_pkg::*;
#(
  parameter int NUM_FU     = DEF_NUM_FU,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int HIST_DEPTH = DEF_HIST_DEPTH,
  parameter int REG_W      = DEF_REG_W,
  parameter int DATA_W     = DEF_DATA_W,
  localparam int LVL_W     = lvl_width(HIST_DEPTH)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      flush,
  input  logic                      hold,
  input  logic [NUM_FU-1:0]         fu_valid,
  input  logic [NUM_FU*REG_W-1:0]   fu_rd,
  input  logic [NUM_FU*DATA_W-1:0]  fu_data,
  input  logic [NUM_SRC*REG_W-1:0]  src_reg,
  output logic [NUM_SRC-1:0]        src_bypass_ena,
  output logic [NUM_SRC*DATA_W-1:0] src_bypass_data,
  output logic [NUM_SRC*LVL_W-1:0]  src_bypass_level,
  output logic [15:0]               hit_count
);

  localparam int HIST_ENT = HIST_DEPTH * NUM_FU;
  localparam int NUM_ENT  = HIST_ENT + NUM_FU;

  logic [NUM_FU-1:0]          live_valid;
  logic [HIST_ENT-1:0]        hist_valid_q, hist_valid_d;
  logic [HIST_ENT*REG_W-1:0]  hist_rd_q, hist_rd_d;
  logic [HIST_ENT*DATA_W-1:0] hist_data_q, hist_data_d;
  logic [15:0]                hit_count_q, hit_count_d;

  // Full entry array: live channels at the bottom, then level 1 .. HIST_DEPTH.
  logic [NUM_ENT-1:0]         ent_valid;
  logic [NUM_ENT*REG_W-1:0]   ent_rd;
  logic [NUM_ENT*DATA_W-1:0]  ent_data;

  always_comb begin
    live_valid = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      live_valid[i] = fu_valid[i] && (fu_rd[i*REG_W +: REG_W] != '0) && !flush;
    end
  end

  assign ent_valid = {hist_valid_q, live_valid};
  assign ent_rd    = {hist_rd_q, fu_rd};
  assign ent_data  = {hist_data_q, fu_data};

  // Shifting by one level is just dropping the oldest NUM_FU entries of the
  // combined array, which leaves live -> level 1, level k -> level k+1.
  always_comb begin
    hist_valid_d = hist_valid_q;
    hist_rd_d    = hist_rd_q;
    hist_data_d  = hist_data_q;
    if (flush) begin
      hist_valid_d = '0;
    end else if (!hold) begin
      hist_valid_d = ent_valid[HIST_ENT-1:0];
      hist_rd_d    = ent_rd[HIST_ENT*REG_W-1:0];
      hist_data_d  = ent_data[HIST_ENT*DATA_W-1:0];
    end
  end

  always_comb begin
    hit_count_d = hit_count_q;
    if ((|src_bypass_ena) && (hit_count_q != 16'hFFFF)) begin
      hit_count_d = hit_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hist_valid_q <= '0;
      hit_count_q  <= '0;
    end else begin
      hist_valid_q <= hist_valid_d;
      hit_count_q  <= hit_count_d;
    end
  end

  // Payload of invalid entries is never observed, so it needs no reset.
  always_ff @(posedge CLK) begin
    hist_rd_q   <= hist_rd_d;
    hist_data_q <= hist_data_d;
  end

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    ooo_bypass_lookup #(
      .NUM_ENT     (NUM_ENT),
      .ENT_PER_LVL (NUM_FU),
      .REG_W       (REG_W),
      .DATA_W      (DATA_W),
      .LVL_W       (LVL_W)
    ) u_lookup (
      .enable    (nRST && !flush),
      .ent_valid (ent_valid),
      .ent_rd    (ent_rd),
      .ent_data  (ent_data),
      .src_reg   (src_reg[p*REG_W +: REG_W]),
      .hit       (src_bypass_ena[p]),
      .hit_data  (src_bypass_data[p*DATA_W +: DATA_W]),
      .hit_level (src_bypass_level[p*LVL_W +: LVL_W])
    );
  end

  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_ooo_bypass_network.sv
// tb/tb_ooo_bypass_network.sv - self-checking bench for ooo_bypass_network
module tb_ooo_bypass_network;
  import ooo_bypass_pkg::*;

  localparam int NUM_FU     = 4;
  localparam int NUM_SRC    = 2;
  localparam int HIST_DEPTH = 2;
  localparam int REG_W      = 5;
  localparam int DATA_W     = 32;
  localparam int LVL_W      = lvl_width(HIST_DEPTH);

  logic                      clk = 1'b0;
  logic                      n_rst;
  logic                      flush;
  logic                      hold;
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU*REG_W-1:0]   fu_rd;
  logic [NUM_FU*DATA_W-1:0]  fu_data;
  logic [NUM_SRC*REG_W-1:0]  src_reg;
  logic [NUM_SRC-1:0]        src_bypass_ena;
  logic [NUM_SRC*DATA_W-1:0] src_bypass_data;
  logic [NUM_SRC*LVL_W-1:0]  src_bypass_level;
  logic [15:0]               hit_count;

  int checks = 0;
  int errors = 0;

  ooo_bypass_network #(
    .NUM_FU(NUM_FU), .NUM_SRC(NUM_SRC), .HIST_DEPTH(HIST_DEPTH),
    .REG_W(REG_W), .DATA_W(DATA_W)
  ) dut (
    .CLK              (clk),
    .nRST             (n_rst),
    .flush            (flush),
    .hold             (hold),
    .fu_valid         (fu_valid),
    .fu_rd            (fu_rd),
    .fu_data          (fu_data),
    .src_reg          (src_reg),
    .src_bypass_ena   (src_bypass_ena),
    .src_bypass_data  (src_bypass_data),
    .src_bypass_level (src_bypass_level),
    .hit_count        (hit_count)
  );

  always #5 clk = ~clk;

  // Reference model: history as an array of per-cycle snapshots of what was written.
  typedef struct {
    bit              v;
    bit [REG_W-1:0]  rd;
    bit [DATA_W-1:0] d;
  } ment_t;

  ment_t           mh [HIST_DEPTH][NUM_FU];
  int              m_cnt;
  bit              exp_ena  [NUM_SRC];
  bit [DATA_W-1:0] exp_data [NUM_SRC];
  int              exp_lvl  [NUM_SRC];

  function automatic void model_lookup(input logic [REG_W-1:0] r, output bit ena,
                                       output bit [DATA_W-1:0] d, output int lvl);
    ena = 0; d = '0; lvl = 0;
    if (n_rst !== 1'b1 || flush || r == '0) return;
    for (int ch = 0; ch < NUM_FU; ch++) begin
      if (fu_valid[ch] && fu_rd[ch*REG_W +: REG_W] == r) begin
        ena = 1; d = fu_data[ch*DATA_W +: DATA_W]; lvl = 0;
        return;
      end
    end
    for (int k = 0; k < HIST_DEPTH; k++) begin
      for (int ch = 0; ch < NUM_FU; ch++) begin
        if (mh[k][ch].v && mh[k][ch].rd == r) begin
          ena = 1; d = mh[k][ch].d; lvl = k + 1;
          return;
        end
      end
    end
  endfunction

  task automatic settle();
    @(negedge clk);
    for (int p = 0; p < NUM_SRC; p++) begin
      model_lookup(src_reg[p*REG_W +: REG_W], exp_ena[p], exp_data[p], exp_lvl[p]);
    end
  endtask

  task automatic clock_edge();
    bit any;
    any = 0;
    for (int p = 0; p < NUM_SRC; p++) any |= exp_ena[p];
    @(posedge clk);
    if (!n_rst) begin
      for (int k = 0; k < HIST_DEPTH; k++)
        for (int ch = 0; ch < NUM_FU; ch++) mh[k][ch].v = 0;
      m_cnt = 0;
    end else begin
      if (any && m_cnt < 65535) m_cnt++;
      if (flush) begin
        for (int k = 0; k < HIST_DEPTH; k++)
          for (int ch = 0; ch < NUM_FU; ch++) mh[k][ch].v = 0;
      end else if (!hold) begin
        for (int k = HIST_DEPTH - 1; k > 0; k--)
          for (int ch = 0; ch < NUM_FU; ch++) mh[k][ch] = mh[k-1][ch];
        for (int ch = 0; ch < NUM_FU; ch++) begin
          mh[0][ch].rd = fu_rd[ch*REG_W +: REG_W];
          mh[0][ch].d  = fu_data[ch*DATA_W +: DATA_W];
          mh[0][ch].v  = fu_valid[ch] && (fu_rd[ch*REG_W +: REG_W] != '0);
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    fu_valid = '0; fu_rd = '0; fu_data = '0; src_reg = '0; flush = 0; hold = 0;
  endtask

  task automatic set_fu(input int ch, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d);
    fu_valid[ch] = 1'b1;
    fu_rd[ch*REG_W +: REG_W] = rd;
    fu_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) begin settle(); clock_edge(); end
  endtask

  task automatic test_reset();
    n_rst = 0;
    clear_inputs();
    set_fu(0, 5'd5, 32'hAAAA);
    src_reg = {5'd5, 5'd5};
    settle();
    checks++;
    if (src_bypass_ena !== '0 || src_bypass_data !== '0 || src_bypass_level !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ena=%b data=%h lvl=%h, want all zero",
               src_bypass_ena, src_bypass_data, src_bypass_level);
    end
    clock_edge();
    settle();
    checks++;
    if (hit_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: hit_count=%0d, want 0", hit_count);
    end
    clock_edge();
    n_rst = 1;
    idle(1);
  endtask

  task automatic test_live_hit();
    idle(3);
    set_fu(0, 5'd5, 32'hAAAA);
    src_reg = {5'd6, 5'd5};
    settle();
    checks++;
    if (src_bypass_ena[0] !== 1'b1 || src_bypass_data[DATA_W-1:0] !== 32'hAAAA ||
        src_bypass_level[LVL_W-1:0] !== '0) begin
      errors++;
      $display("FAIL live_hit: ena=%b data=%h lvl=%0d, want 1 0000aaaa 0",
               src_bypass_ena[0], src_bypass_data[DATA_W-1:0], src_bypass_level[LVL_W-1:0]);
    end
    checks++;
    if (src_bypass_ena[1] !== 1'b0 || src_bypass_data[2*DATA_W-1:DATA_W] !== '0) begin
      errors++;
      $display("FAIL live_miss_port1: ena=%b data=%h, want 0 0",
               src_bypass_ena[1], src_bypass_data[2*DATA_W-1:DATA_W]);
    end
    clock_edge();
  endtask

  task automatic test_history_expiry();
    bit              want_ena [4];
    int              want_lvl [4];
    want_ena = '{1, 1, 1, 0};
    want_lvl = '{0, 1, 2, 0};
    idle(3);
    set_fu(0, 5'd7, 32'h1234);
    src_reg = {5'd0, 5'd7};
    for (int t = 0; t < 4; t++) begin
      settle();
      checks++;
      if (src_bypass_ena[0] !== want_ena[t] ||
          src_bypass_data[DATA_W-1:0] !== (want_ena[t] ? 32'h1234 : 32'h0) ||
          src_bypass_level[LVL_W-1:0] !== LVL_W'(want_lvl[t])) begin
        errors++;
        $display("FAIL hist_expiry t+%0d: ena=%b data=%h lvl=%0d, want %b lvl %0d", t,
                 src_bypass_ena[0], src_bypass_data[DATA_W-1:0],
                 src_bypass_level[LVL_W-1:0], want_ena[t], want_lvl[t]);
      end
      clock_edge();
      fu_valid = '0;
    end
  endtask

  task automatic test_priority();
    idle(3);
    set_fu(1, 5'd3, 32'd11);
    settle(); clock_edge();
    clear_inputs();
    set_fu(0, 5'd3, 32'd22);
    src_reg = {5'd0, 5'd3};
    settle();
    checks++;
    if (src_bypass_data[DATA_W-1:0] !== 32'd22 || src_bypass_level[LVL_W-1:0] !== '0) begin
      errors++;
      $display("FAIL prio_newest: data=%0d lvl=%0d, want 22 0",
               src_bypass_data[DATA_W-1:0], src_bypass_level[LVL_W-1:0]);
    end
    clock_edge();
    clear_inputs();
    set_fu(3, 5'd3, 32'h44);
    set_fu(0, 5'd3, 32'h33);
    src_reg = {5'd3, 5'd3};
    settle();
    checks++;
    if (src_bypass_data !== {32'h33, 32'h33} || src_bypass_ena !== 2'b11) begin
      errors++;
      $display("FAIL prio_channel: ena=%b data=%h, want 11 00000033_00000033",
               src_bypass_ena, src_bypass_data);
    end
    clock_edge();
  endtask

  task automatic test_x0_hold();
    bit want_ena [6];
    int want_lvl [6];
    idle(3);
    set_fu(0, 5'd0, 32'hFF);
    src_reg = '0;
    settle();
    checks++;
    if (src_bypass_ena !== '0 || src_bypass_data !== '0) begin
      errors++; $display("FAIL x0_live: ena=%b data=%h, want 0 0", src_bypass_ena, src_bypass_data);
    end
    clock_edge();
    clear_inputs();
    settle();
    checks++;
    if (src_bypass_ena !== '0) begin
      errors++; $display("FAIL x0_hist: ena=%b, want 00", src_bypass_ena);
    end
    clock_edge();
    set_fu(2, 5'd9, 32'h55);
    src_reg = {5'd0, 5'd9};
    settle(); clock_edge();
    fu_valid = '0;
    want_ena = '{1, 1, 1, 1, 1, 0};
    want_lvl = '{1, 1, 1, 1, 2, 0};
    for (int t = 0; t < 6; t++) begin
      hold = (t < 3);
      settle();
      checks++;
      if (src_bypass_ena[0] !== want_ena[t] ||
          src_bypass_data[DATA_W-1:0] !== (want_ena[t] ? 32'h55 : 32'h0) ||
          src_bypass_level[LVL_W-1:0] !== LVL_W'(want_lvl[t])) begin
        errors++;
        $display("FAIL hold step %0d: ena=%b data=%h lvl=%0d, want %b lvl %0d", t,
                 src_bypass_ena[0], src_bypass_data[DATA_W-1:0],
                 src_bypass_level[LVL_W-1:0], want_ena[t], want_lvl[t]);
      end
      clock_edge();
    end
    hold = 0;
  endtask

  task automatic test_flush();
    idle(3);
    set_fu(0, 5'd4, 32'h4444);
    settle(); clock_edge();
    clear_inputs();
    src_reg = {5'd4, 5'd4};
    set_fu(1, 5'd4, 32'h9999);
    flush = 1;
    settle();
    checks++;
    if (src_bypass_ena !== '0 || src_bypass_data !== '0) begin
      errors++;
      $display("FAIL flush_cycle: ena=%b data=%h, want 0 0", src_bypass_ena, src_bypass_data);
    end
    clock_edge();
    flush = 0;
    fu_valid = '0;
    settle();
    checks++;
    if (src_bypass_ena !== '0) begin
      errors++; $display("FAIL flush_after: ena=%b, want 00", src_bypass_ena);
    end
    clock_edge();
  endtask

  task automatic test_reset_mid();
    idle(2);
    set_fu(2, 5'd12, 32'hBEEF);
    src_reg = {5'd12, 5'd12};
    settle(); clock_edge();
    settle(); clock_edge();
    n_rst = 0; hold = 1; flush = 1;
    settle();
    checks++;
    if (src_bypass_ena !== '0 || src_bypass_data !== '0 || src_bypass_level !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: ena=%b data=%h, want 0 0", src_bypass_ena, src_bypass_data);
    end
    clock_edge();
    settle();
    checks++;
    if (hit_count !== 16'd0) begin
      errors++; $display("FAIL rst_mid_count: hit_count=%0d, want 0", hit_count);
    end
    clock_edge();
    n_rst = 1; hold = 0; flush = 0; fu_valid = '0;
    settle();
    checks++;
    if (src_bypass_ena !== '0) begin
      errors++; $display("FAIL rst_mid_hist: ena=%b, want 00", src_bypass_ena);
    end
    clock_edge();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      n_rst = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 11) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      for (int ch = 0; ch < NUM_FU; ch++) begin
        fu_valid[ch] = $urandom_range(0, 1);
        fu_rd[ch*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
        fu_data[ch*DATA_W +: DATA_W] = $urandom;
      end
      for (int p = 0; p < NUM_SRC; p++) src_reg[p*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
      settle();
      for (int p = 0; p < NUM_SRC; p++) begin
        checks++;
        if (src_bypass_ena[p] !== exp_ena[p] ||
            src_bypass_data[p*DATA_W +: DATA_W] !== exp_data[p] ||
            src_bypass_level[p*LVL_W +: LVL_W] !== LVL_W'(exp_lvl[p])) begin
          errors++;
          $display("FAIL random c%0d p%0d: ena=%b data=%h lvl=%0d, want %b %h %0d", c, p,
                   src_bypass_ena[p], src_bypass_data[p*DATA_W +: DATA_W],
                   src_bypass_level[p*LVL_W +: LVL_W], exp_ena[p], exp_data[p], exp_lvl[p]);
        end
      end
      checks++;
      if (hit_count !== 16'(m_cnt)) begin
        errors++; $display("FAIL random_count c%0d: hit_count=%0d, want %0d", c, hit_count, m_cnt);
      end
      clock_edge();
    end
    n_rst = 1;
    clear_inputs();
  endtask

  task automatic test_saturation();
    clear_inputs();
    n_rst = 0;
    settle(); clock_edge();
    n_rst = 1;
    set_fu(0, 5'd1, 32'h1);
    src_reg = {5'd0, 5'd1};
    for (int i = 0; i < 65534; i++) begin settle(); clock_edge(); end
    settle();
    checks++;
    if (hit_count !== 16'hFFFE) begin
      errors++; $display("FAIL sat_before: hit_count=%h, want fffe", hit_count);
    end
    clock_edge();
    settle();
    checks++;
    if (hit_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach: hit_count=%h, want ffff", hit_count);
    end
    clock_edge();
    for (int i = 0; i < 5; i++) begin settle(); clock_edge(); end
    settle();
    checks++;
    if (hit_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_held: hit_count=%h, want ffff", hit_count);
    end
    clock_edge();
  endtask

  initial begin
    for (int k = 0; k < HIST_DEPTH; k++)
      for (int ch = 0; ch < NUM_FU; ch++) mh[k][ch] = '{v: 0, rd: '0, d: '0};
    m_cnt = 0;
    for (int p = 0; p < NUM_SRC; p++) begin exp_ena[p] = 0; exp_data[p] = '0; exp_lvl[p] = 0; end
    n_rst = 0;
    clear_inputs();
    test_reset();
    test_live_hit();
    test_history_expiry();
    test_priority();
    test_x0_hold();
    test_flush();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
